// File: rtl/safecrack_pkg.sv
// Shared types and helpers for the safecrack lock controller family.
// Build option: SAFECRACK_ESCALATE_EN (escalating lockout duration) is handled in the top.
package safecrack_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Buttons are active-low, so "nothing pressed" is all-ones at the button width.
  function automatic logic [31:0] idle_val(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Board default code for the 4-digit, 4-button configuration: E, D, B, 7.
  localparam logic [15:0] SAFECRACK_DEFAULT_CODE = 16'h7BDE;

endpackage

// File: rtl/safecrack_press_detect.sv
// Turns the debounced active-low button vector into single-cycle press events.
// A press is an idle-to-non-idle transition; holds and releases produce nothing.
module safecrack_press_detect
  import safecrack_pkg::*;
#(
  parameter int BTN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn_i,
  output logic             press_o,
  output logic [BTN_W-1:0] press_val_o
);

  localparam logic [31:0]      IDLE32 = idle_val(BTN_W);
  localparam logic [BTN_W-1:0] IDLE   = IDLE32[BTN_W-1:0];

  logic [BTN_W-1:0] btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= IDLE;
    else     btn_q <= btn_i;
  end

  assign press_o     = (btn_q == IDLE) && (btn_i != IDLE);
  assign press_val_o = btn_i;

endmodule

// File: rtl/safecrack_param_fsm.sv
// Parametrised combination-lock controller: whole-attempt judging, tick-timed lockout,
// atomic reprogramming while open. Define SAFECRACK_ESCALATE_EN for doubling lockouts.
module safecrack_param_fsm
  import safecrack_pkg::*;
#(
  parameter int CODE_LEN  = 4,
  parameter int BTN_W     = 4,
  parameter int MAX_ERR   = 3,
  parameter int LOCK_SECS = 10,
  parameter logic [CODE_LEN*BTN_W-1:0] DEFAULT_CODE = SAFECRACK_DEFAULT_CODE,
  localparam int EW = $clog2(MAX_ERR+1),
`ifdef SAFECRACK_ESCALATE_EN
  localparam int CNT_W = $clog2(LOCK_SECS*8+1)
`else
  localparam int CNT_W = $clog2(LOCK_SECS+1)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [BTN_W-1:0]    btn,
  input  logic                ms,
  input  logic                relock,
  output logic                unlocked,
  output logic                lockout,
  output logic                prog_active,
  output logic [EW-1:0]       err_cnt,
  output logic [CODE_LEN-1:0] leds_progress,
  output logic [CNT_W-1:0]    secs_left
);

  localparam int CW    = CODE_LEN * BTN_W;
  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [EW-1:0]    ERR_LIMIT = EW'(MAX_ERR);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             flag_q, flag_d;
  logic [EW-1:0]    err_q, err_d;
  logic [CNT_W-1:0] secs_q, secs_d;
  logic [CW-1:0]    code_q, code_d;
  logic [CW-1:0]    shadow_q, shadow_d;

  logic             press;
  logic [BTN_W-1:0] press_val;
  logic             mism;
  logic [EW-1:0]    err_inc;
  logic [CNT_W-1:0] lock_dur;

`ifdef SAFECRACK_ESCALATE_EN
  logic [1:0] level_q, level_d;
  assign lock_dur = CNT_W'(LOCK_SECS) << level_q;
`else
  assign lock_dur = CNT_W'(LOCK_SECS);
`endif

  safecrack_press_detect #(.BTN_W(BTN_W)) u_press (
    .clk         (clk),
    .rst         (rst),
    .btn_i       (btn),
    .press_o     (press),
    .press_val_o (press_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      flag_q  <= 1'b0;
      err_q   <= '0;
      secs_q  <= '0;
      code_q  <= DEFAULT_CODE;
`ifdef SAFECRACK_ESCALATE_EN
      level_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      secs_q  <= secs_d;
      code_q  <= code_d;
`ifdef SAFECRACK_ESCALATE_EN
      level_q <= level_d;
`endif
    end
  end

  // Shadow is pure data: stale contents are harmless since every PROG pass rewrites all digits.
  always_ff @(posedge clk) shadow_q <= shadow_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    flag_d   = flag_q;
    err_d    = err_q;
    secs_d   = secs_q;
    code_d   = code_q;
    shadow_d = shadow_q;
`ifdef SAFECRACK_ESCALATE_EN
    level_d  = level_q;
`endif
    mism    = flag_q | (press_val != code_q[idx_q*BTN_W +: BTN_W]);
    err_inc = err_q + 1'b1;

    case (state_q)
      ST_ENTRY: begin
        if (press) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            flag_d = 1'b0;
            if (!mism) begin
              state_d = ST_OPEN;
              err_d   = '0;
`ifdef SAFECRACK_ESCALATE_EN
              level_d = 2'd0;
`endif
            end else begin
              err_d = err_inc;
              if (err_inc == ERR_LIMIT) begin
                state_d = ST_LOCKOUT;
                secs_d  = lock_dur;
`ifdef SAFECRACK_ESCALATE_EN
                level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
`endif
              end
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            flag_d = mism;
          end
        end
      end
      ST_OPEN: begin
        if (ms) begin
          state_d = ST_PROG;
          idx_d   = '0;
        end else if (relock) begin
          state_d = ST_ENTRY;
        end
      end
      ST_PROG: begin
        if (press) begin
          shadow_d[idx_q*BTN_W +: BTN_W] = press_val;
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_d;
            idx_d   = '0;
            state_d = ST_ENTRY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tick) begin
          if (secs_q == CNT_W'(1)) begin
            state_d = ST_ENTRY;
            err_d   = '0;
            secs_d  = '0;
          end else begin
            secs_d = secs_q - 1'b1;
          end
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_comb begin
    leds_progress = '0;
    for (int i = 0; i < CODE_LEN; i++) leds_progress[i] = (32'(idx_q) > i);
  end

  assign unlocked    = (state_q == ST_OPEN);
  assign lockout     = (state_q == ST_LOCKOUT);
  assign prog_active = (state_q == ST_PROG);
  assign err_cnt     = err_q;
  assign secs_left   = secs_q;

endmodule

// File: tb/tb_safecrack_param_fsm.sv
// Directed bench for safecrack_param_fsm in its default 4x4 configuration (E,D,B,7 code).
module tb_safecrack_param_fsm;

  logic       clk = 1'b0;
  logic       rst, tick, ms, relock;
  logic [3:0] btn;
  logic       unlocked, lockout, prog_active;
  logic [1:0] err_cnt;
  logic [3:0] leds_progress;
  logic [3:0] secs_left;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic [3:0] b;
    logic       t, m, rl;
    logic       u, lk, pg;
    logic [1:0] e;
    logic [3:0] ld;
    logic [3:0] sc;
  } vec_t;

  vec_t tbl[$];

  safecrack_param_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .btn           (btn),
    .ms            (ms),
    .relock        (relock),
    .unlocked      (unlocked),
    .lockout       (lockout),
    .prog_active   (prog_active),
    .err_cnt       (err_cnt),
    .leds_progress (leds_progress),
    .secs_left     (secs_left)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] b, input logic t, m, rl,
                     input logic u, lk, pg, input logic [1:0] e,
                     input logic [3:0] ld, sc);
    vec_t v;
    v.r = r; v.b = b; v.t = t; v.m = m; v.rl = rl;
    v.u = u; v.lk = lk; v.pg = pg; v.e = e; v.ld = ld; v.sc = sc;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, then compare all outputs 1 time unit after the edge.
  task automatic step(input string name, input logic r, input logic [3:0] b,
                      input logic t, m, rl, input logic u, lk, pg,
                      input logic [1:0] e, input logic [3:0] ld, sc);
    logic [14:0] got, exp;
    rst = r; btn = b; tick = t; ms = m; relock = rl;
    @(posedge clk);
    #1;
    got = {unlocked, lockout, prog_active, err_cnt, leds_progress, secs_left};
    exp = {u, lk, pg, e, ld, sc};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got unl=%b lko=%b prg=%b err=%0d leds=%b secs=%0d, required unl=%b lko=%b prg=%b err=%0d leds=%b secs=%0d",
               name, unlocked, lockout, prog_active, err_cnt, leds_progress, secs_left,
               u, lk, pg, e, ld, sc);
    end
    rst = 1'b0; btn = 4'hF; tick = 1'b0; ms = 1'b0; relock = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 4'hF; tick = 1'b0; ms = 1'b0; relock = 1'b0;

    // rst  btn  tk ms rl   unl lko prg err leds  secs
    add(1, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h0, 0);   // reset state
    add(0, 4'hF, 0, 1, 0,   0, 0, 0, 0, 4'h0, 0);   // ms ignored in ENTRY
    add(0, 4'hE, 0, 0, 0,   0, 0, 0, 0, 4'h1, 0);   // correct code E,D,B,7
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h1, 0);
    add(0, 4'hD, 0, 0, 0,   0, 0, 0, 0, 4'h3, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h3, 0);
    add(0, 4'hB, 0, 0, 0,   0, 0, 0, 0, 4'h7, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h7, 0);
    add(0, 4'h7, 0, 0, 0,   1, 0, 0, 0, 4'h0, 0);   // unlocked
    add(0, 4'hF, 0, 0, 1,   0, 0, 0, 0, 4'h0, 0);   // relock
    add(0, 4'hE, 0, 0, 0,   0, 0, 0, 0, 4'h1, 0);   // E,0,B,7: digit 1 wrong
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0,   0, 0, 0, 0, 4'h3, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h3, 0);
    add(0, 4'hB, 0, 0, 0,   0, 0, 0, 0, 4'h7, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h7, 0);
    add(0, 4'h7, 0, 0, 0,   0, 0, 0, 1, 4'h0, 0);   // judged wrong
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 1, 4'h0, 0);
    add(0, 4'hE, 0, 0, 0,   0, 0, 0, 1, 4'h1, 0);   // second attempt
    add(0, 4'hE, 0, 0, 0,   0, 0, 0, 1, 4'h1, 0);   // hold: no event
    add(0, 4'h0, 0, 0, 0,   0, 0, 0, 1, 4'h1, 0);   // change while held: no event
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 1, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0,   0, 0, 0, 1, 4'h3, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 1, 4'h3, 0);
    add(0, 4'h0, 0, 0, 0,   0, 0, 0, 1, 4'h7, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 1, 4'h7, 0);
    add(0, 4'h0, 0, 0, 0,   0, 0, 0, 2, 4'h0, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 2, 4'h0, 0);
    add(0, 4'h1, 0, 0, 0,   0, 0, 0, 2, 4'h1, 0);   // third attempt
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 2, 4'h1, 0);
    add(0, 4'h1, 0, 0, 0,   0, 0, 0, 2, 4'h3, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 2, 4'h3, 0);
    add(0, 4'h1, 0, 0, 0,   0, 0, 0, 2, 4'h7, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 2, 4'h7, 0);
    add(0, 4'h1, 1, 0, 0,   0, 1, 0, 3, 4'h0, 10);  // lockout entry, tick ignored
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 9);
    add(0, 4'hE, 1, 0, 0,   0, 1, 0, 3, 4'h0, 8);   // press+tick: tick only
    add(0, 4'hF, 0, 0, 0,   0, 1, 0, 3, 4'h0, 8);
    add(0, 4'hD, 1, 0, 0,   0, 1, 0, 3, 4'h0, 7);
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 6);
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 5);
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 4);
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 3);
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 2);
    add(0, 4'hF, 1, 0, 0,   0, 1, 0, 3, 4'h0, 1);
    add(0, 4'hF, 1, 0, 0,   0, 0, 0, 0, 4'h0, 0);   // 10th tick: back to ENTRY
    add(0, 4'hE, 0, 0, 0,   0, 0, 0, 0, 4'h1, 0);   // unlock again
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h1, 0);
    add(0, 4'hD, 0, 0, 0,   0, 0, 0, 0, 4'h3, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h3, 0);
    add(0, 4'hB, 0, 0, 0,   0, 0, 0, 0, 4'h7, 0);
    add(0, 4'hF, 0, 0, 0,   0, 0, 0, 0, 4'h7, 0);
    add(0, 4'h7, 0, 0, 0,   1, 0, 0, 0, 4'h0, 0);

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].r, tbl[i].b, tbl[i].t, tbl[i].m, tbl[i].rl,
           tbl[i].u, tbl[i].lk, tbl[i].pg, tbl[i].e, tbl[i].ld, tbl[i].sc);

    // Reprogram to 1,2,4,8: ms beats relock; ms held in PROG has no effect.
    step("prog_enter", 0, 4'hF, 0, 1, 1,  0, 0, 1, 0, 4'h0, 0);
    step("prog_d0",    0, 4'h1, 0, 1, 0,  0, 0, 1, 0, 4'h1, 0);
    step("prog_i0",    0, 4'hF, 0, 0, 0,  0, 0, 1, 0, 4'h1, 0);
    step("prog_d1",    0, 4'h2, 0, 0, 0,  0, 0, 1, 0, 4'h3, 0);
    step("prog_i1",    0, 4'hF, 0, 0, 0,  0, 0, 1, 0, 4'h3, 0);
    step("prog_d2",    0, 4'h4, 0, 0, 0,  0, 0, 1, 0, 4'h7, 0);
    step("prog_i2",    0, 4'hF, 0, 0, 0,  0, 0, 1, 0, 4'h7, 0);
    step("prog_commit",0, 4'h8, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0);
    step("prog_i3",    0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0);
    // Old code now fails.
    step("old_d0",     0, 4'hE, 0, 0, 0,  0, 0, 0, 0, 4'h1, 0);
    step("old_i0",     0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h1, 0);
    step("old_d1",     0, 4'hD, 0, 0, 0,  0, 0, 0, 0, 4'h3, 0);
    step("old_i1",     0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h3, 0);
    step("old_d2",     0, 4'hB, 0, 0, 0,  0, 0, 0, 0, 4'h7, 0);
    step("old_i2",     0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h7, 0);
    step("old_d3",     0, 4'h7, 0, 0, 0,  0, 0, 0, 1, 4'h0, 0);
    step("old_i3",     0, 4'hF, 0, 0, 0,  0, 0, 0, 1, 4'h0, 0);
    // New code unlocks and clears err_cnt.
    step("new_d0",     0, 4'h1, 0, 0, 0,  0, 0, 0, 1, 4'h1, 0);
    step("new_i0",     0, 4'hF, 0, 0, 0,  0, 0, 0, 1, 4'h1, 0);
    step("new_d1",     0, 4'h2, 0, 0, 0,  0, 0, 0, 1, 4'h3, 0);
    step("new_i1",     0, 4'hF, 0, 0, 0,  0, 0, 0, 1, 4'h3, 0);
    step("new_d2",     0, 4'h4, 0, 0, 0,  0, 0, 0, 1, 4'h7, 0);
    step("new_i2",     0, 4'hF, 0, 0, 0,  0, 0, 0, 1, 4'h7, 0);
    step("new_d3",     0, 4'h8, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0);
    // Reset in the middle of a programming pass restores the default code.
    step("rprog_enter",0, 4'hF, 0, 1, 0,  0, 0, 1, 0, 4'h0, 0);
    step("rprog_d0",   0, 4'h1, 0, 0, 0,  0, 0, 1, 0, 4'h1, 0);
    step("rprog_i0",   0, 4'hF, 0, 0, 0,  0, 0, 1, 0, 4'h1, 0);
    step("rprog_d1",   0, 4'h2, 0, 0, 0,  0, 0, 1, 0, 4'h3, 0);
    step("rprog_rst",  1, 4'h2, 1, 1, 1,  0, 0, 0, 0, 4'h0, 0);
    step("dflt_d0",    0, 4'hE, 0, 0, 0,  0, 0, 0, 0, 4'h1, 0);
    step("dflt_i0",    0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h1, 0);
    step("dflt_d1",    0, 4'hD, 0, 0, 0,  0, 0, 0, 0, 4'h3, 0);
    step("dflt_i1",    0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h3, 0);
    step("dflt_d2",    0, 4'hB, 0, 0, 0,  0, 0, 0, 0, 4'h7, 0);
    step("dflt_i2",    0, 4'hF, 0, 0, 0,  0, 0, 0, 0, 4'h7, 0);
    step("dflt_d3",    0, 4'h7, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
